// File: rtl/motoro3_pkg.sv
// Shared types and constants for the motoro3 gate driver.
// MOTORO3_GATE_ACTIVE_LOW_EN selects active-low gate outputs (all-off level = 1).
package motoro3_pkg;

  typedef enum logic [1:0] {
    PH_OFF  = 2'd0,
    PH_HIGH = 2'd1,
    PH_LOW  = 2'd2,
    PH_DEAD = 2'd3
  } phase_state_t;

  localparam logic [3:0] STEP_IDLE = 4'd0;
  localparam logic [3:0] STEP_STOP = 4'd7;

  localparam int DEADTIME_DEFAULT = 20;

`ifdef MOTORO3_GATE_ACTIVE_LOW_EN
  localparam logic GATE_OFF = 1'b1;
`else
  localparam logic GATE_OFF = 1'b0;
`endif

  function automatic logic step_runs(input logic [3:0] step);
    return !((step == STEP_IDLE) || (step == STEP_STOP));
  endfunction

endpackage

// File: rtl/motoro3_gate_phase.sv
// One phase leg: OFF/HIGH/LOW/DEAD state machine with dead-time counter.
// Gate polarity follows MOTORO3_GATE_ACTIVE_LOW_EN via motoro3_pkg::GATE_OFF.
module motoro3_gate_phase
  import motoro3_pkg::*;
#(
  parameter int DEADTIME_CYC = DEADTIME_DEFAULT,
  parameter int DT_W         = 8
) (
  input  logic clk,
  input  logic nRst,
  input  logic req_h,
  input  logic req_l,
  input  logic force_off,
  output logic ho,
  output logic lo,
  output logic dead
);

  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME_CYC - 1);

  phase_state_t    state_reg;
  logic [DT_W-1:0] cnt_reg;

  assign dead = (state_reg == PH_DEAD);

  // Gate flops are written alongside the state so they always mirror its decode.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg <= PH_OFF;
      cnt_reg   <= '0;
      ho        <= GATE_OFF;
      lo        <= GATE_OFF;
    end else begin
      ho <= GATE_OFF;
      lo <= GATE_OFF;
      if (force_off) begin
        state_reg <= PH_OFF;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          PH_OFF: begin
            if (req_h) begin
              state_reg <= PH_HIGH;
              ho        <= ~GATE_OFF;
            end else if (req_l) begin
              state_reg <= PH_LOW;
              lo        <= ~GATE_OFF;
            end
          end
          PH_HIGH: begin
            if (req_h) begin
              ho <= ~GATE_OFF;
            end else begin
              state_reg <= PH_DEAD;
              cnt_reg   <= DT_LOAD;
            end
          end
          PH_LOW: begin
            if (req_l) begin
              lo <= ~GATE_OFF;
            end else begin
              state_reg <= PH_DEAD;
              cnt_reg   <= DT_LOAD;
            end
          end
          PH_DEAD: begin
            // Requests are only looked at once the full blanking interval has run.
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - 1'b1;
            end else if (req_h) begin
              state_reg <= PH_HIGH;
              ho        <= ~GATE_OFF;
            end else if (req_l) begin
              state_reg <= PH_LOW;
              lo        <= ~GATE_OFF;
            end else begin
              state_reg <= PH_OFF;
            end
          end
          default: state_reg <= PH_OFF;
        endcase
      end
    end
  end

endmodule

// File: rtl/motoro3_gate_driver.sv
// Three-phase gate driver: request decode, fault latch and three dead-time legs.
// Define MOTORO3_GATE_ACTIVE_LOW_EN for active-low gate outputs.
module motoro3_gate_driver
  import motoro3_pkg::*;
#(
  parameter int DEADTIME_CYC = DEADTIME_DEFAULT,
  parameter int DT_W         = 8
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       pwm,
  input  logic       aE,
  input  logic       bE,
  input  logic       cE,
  input  logic       aH1_L0,
  input  logic       bH1_L0,
  input  logic       cH1_L0,
  input  logic [3:0] m3step,
  input  logic       flt_n,
  input  logic       flt_clr,
  output logic       aHo,
  output logic       aLo,
  output logic       bHo,
  output logic       bLo,
  output logic       cHo,
  output logic       cLo,
  output logic       fault,
  output logic       dt_busy
);

  logic [1:0] flt_sync_reg;
  logic       fault_reg;
  logic       run;
  logic       force_off;
  logic [2:0] en, pol, req_h, req_l, ho, lo, dead;

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      flt_sync_reg <= 2'b11;
      fault_reg    <= 1'b0;
    end else begin
      flt_sync_reg <= {flt_sync_reg[0], flt_n};
      if (!flt_sync_reg[1]) begin
        fault_reg <= 1'b1;
      end else if (flt_clr) begin
        fault_reg <= 1'b0;
      end
    end
  end

  // Including the live synchronizer output lets the legs drop on the same edge the latch sets.
  assign force_off = fault_reg | ~flt_sync_reg[1];
  assign run       = step_runs(m3step) & ~fault_reg;

  assign en    = {cE, bE, aE};
  assign pol   = {cH1_L0, bH1_L0, aH1_L0};
  assign req_h = {3{run & pwm}} & en & pol;
  assign req_l = {3{run}} & en & ~pol;

  for (genvar gi = 0; gi < 3; gi++) begin : g_phase
    motoro3_gate_phase #(
      .DEADTIME_CYC(DEADTIME_CYC),
      .DT_W        (DT_W)
    ) u_phase (
      .clk      (clk),
      .nRst     (nRst),
      .req_h    (req_h[gi]),
      .req_l    (req_l[gi]),
      .force_off(force_off),
      .ho       (ho[gi]),
      .lo       (lo[gi]),
      .dead     (dead[gi])
    );
  end

  assign {cHo, bHo, aHo} = ho;
  assign {cLo, bLo, aLo} = lo;
  assign fault           = fault_reg;
  assign dt_busy         = |dead;

endmodule

// File: tb/tb_motoro3_gate_driver.sv
// Directed plus randomized bench for motoro3_gate_driver against a timeline model.
// Honors MOTORO3_GATE_ACTIVE_LOW_EN by inverting expected gate levels.
module tb_motoro3_gate_driver;

  localparam int DT = 20;
`ifdef MOTORO3_GATE_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nRst;
  logic       pwm;
  logic [2:0] e, pol;
  logic [3:0] m3step;
  logic       flt_n, flt_clr;
  logic       aHo, aLo, bHo, bLo, cHo, cLo, fault, dt_busy;

  always #50 clk = ~clk;

  motoro3_gate_driver #(.DEADTIME_CYC(DT), .DT_W(8)) dut (
    .clk(clk), .nRst(nRst), .pwm(pwm),
    .aE(e[0]), .bE(e[1]), .cE(e[2]),
    .aH1_L0(pol[0]), .bH1_L0(pol[1]), .cH1_L0(pol[2]),
    .m3step(m3step), .flt_n(flt_n), .flt_clr(flt_clr),
    .aHo(aHo), .aLo(aLo), .bHo(bHo), .bLo(bLo), .cHo(cHo), .cLo(cLo),
    .fault(fault), .dt_busy(dt_busy)
  );

  // Model: which side conducts (0 none, 1 high, 2 low) and remaining blanking edges.
  int m_side [3];
  int m_blank[3];
  bit m_fault, m_s1, m_s2;
  int vectors = 0;
  int miscompares = 0;

  function automatic void model_reset();
    for (int p = 0; p < 3; p++) begin
      m_side[p]  = 0;
      m_blank[p] = 0;
    end
    m_fault = 0;
    m_s1    = 1;
    m_s2    = 1;
  endfunction

  function automatic void model_edge();
    bit kill, running, rh, rl;
    int want;
    kill    = m_fault || !m_s2;
    running = (m3step != 4'd0) && (m3step != 4'd7) && !m_fault;
    for (int p = 0; p < 3; p++) begin
      rh   = running && e[p] && pol[p] && pwm;
      rl   = running && e[p] && !pol[p];
      want = rh ? 1 : (rl ? 2 : 0);
      if (kill) begin
        m_side[p]  = 0;
        m_blank[p] = 0;
      end else if (m_blank[p] > 0) begin
        m_blank[p]--;
        if (m_blank[p] == 0) m_side[p] = want;
      end else if (m_side[p] == 0) begin
        m_side[p] = want;
      end else if ((m_side[p] == 1 && !rh) || (m_side[p] == 2 && !rl)) begin
        m_side[p]  = 0;
        m_blank[p] = DT;
      end
    end
    if (!m_s2) m_fault = 1;
    else if (flt_clr) m_fault = 0;
    m_s2 = m_s1;
    m_s1 = flt_n;
  endfunction

  function automatic logic [7:0] model_vec();
    logic [7:0] v;
    v[7] = (m_side[0] == 1) ^ INV;
    v[6] = (m_side[0] == 2) ^ INV;
    v[5] = (m_side[1] == 1) ^ INV;
    v[4] = (m_side[1] == 2) ^ INV;
    v[3] = (m_side[2] == 1) ^ INV;
    v[2] = (m_side[2] == 2) ^ INV;
    v[1] = m_fault;
    v[0] = (m_blank[0] > 0) || (m_blank[1] > 0) || (m_blank[2] > 0);
    return v;
  endfunction

  task automatic check(input string tag);
    logic [7:0] got, exp;
    got = {aHo, aLo, bHo, bLo, cHo, cLo, fault, dt_busy};
    exp = model_vec();
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got {aH,aL,bH,bL,cH,cL,flt,busy}=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    model_edge();
    @(posedge clk);
    check(tag);
  endtask

  initial begin
    int gap;
    nRst = 0; pwm = 0; e = '0; pol = '0; m3step = 4'd0; flt_n = 1; flt_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    check("reset");
    nRst = 1;
    step("idle");

    // Step 1: A high side with PWM on, C low side.
    m3step = 4'd1; e = 3'b101; pol = 3'b001; pwm = 1;
    step("step1_on");
    repeat (3) step("step1_hold");

    // A flips high -> low; measure the gap directly as well.
    pol[0] = 1'b0;
    step("a_flip_drop");
    gap = 0;
    do begin
      step("a_flip_dead");
      gap++;
    end while (((aLo ^ INV) == 1'b0) && gap < DT + 5);
    vectors++;
    assert (gap === DT) else begin
      miscompares++;
      $error("FAIL dead_gap: got %0d cycles expected %0d", gap, DT);
    end
    repeat (3) step("a_low_hold");

    // PWM chopping on A high side: slow then every-cycle toggling.
    pol[0] = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (i % 30 == 0) pwm = ~pwm;
      step("pwm_slow");
    end
    for (int i = 0; i < 40; i++) begin
      pwm = ~pwm;
      step("pwm_fast");
    end
    pwm = 1;
    repeat (DT + 3) step("pwm_settle");

    // One-cycle fault pulse, clear while still low, then clear when high.
    flt_n = 0;
    step("flt_pulse");
    flt_n = 1;
    repeat (4) step("flt_latched");
    flt_n = 0;
    repeat (2) step("flt_low2");
    flt_clr = 1;
    step("clr_ignored");
    flt_clr = 0;
    repeat (2) step("flt_still");
    flt_n = 1;
    repeat (3) step("flt_released");
    flt_clr = 1;
    step("flt_clear");
    flt_clr = 0;
    repeat (4) step("resume");

    // Force stop while conducting high: normal dead-time path to OFF.
    m3step = 4'd7;
    repeat (DT + 3) step("stop_dead");
    m3step = 4'd2;
    repeat (3) step("restart");

    // Asynchronous reset in the middle of a dead interval.
    pol[0] = 1'b0;
    repeat (6) step("pre_rst_dead");
    #10 nRst = 0;
    #1 model_reset();
    check("async_rst");
    @(posedge clk);
    nRst = 1;
    repeat (3) step("post_rst");

    // Randomized run.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) e = 3'($urandom);
      if ($urandom_range(0, 15) == 0) pol = 3'($urandom);
      if ($urandom_range(0, 31) == 0)
        m3step = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(1, 6));
      if ($urandom_range(0, 5) == 0) pwm = ~pwm;
      flt_n   = ($urandom_range(0, 199) != 0);
      flt_clr = ($urandom_range(0, 19) == 0);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
